// File: rtl/soc_top.sv
`default_nettype none
// ============================================================
// Module   : soc_top (+ soc_dbg_regs)
// Purpose  : 8N1 UART echo SoC with boot banner and debug registers
// Revision : 1.0
// ============================================================

module soc_dbg_regs (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_rx_valid,
   input  logic [7:0] i_rx_byte,
   input  logic       i_tx_done,
   input  logic       i_frame_err,
   input  logic       i_overflow
);

   logic [31:0] registers [0:31];

   // Entry 0 and entries 6..31 are only ever written by reset, so they stay zero.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 32; i++) registers[i] <= 32'd0;
      end else begin
         if (i_rx_valid) begin
            registers[1] <= registers[1] + 32'd1;
            registers[3] <= {24'd0, i_rx_byte};
         end
         if (i_tx_done)   registers[2] <= registers[2] + 32'd1;
         if (i_frame_err) registers[4] <= registers[4] + 32'd1;
         if (i_overflow)  registers[5] <= registers[5] + 32'd1;
      end
   end

endmodule

module soc_top #(
   parameter int CLKS_PER_BIT = 278
) (
   input  logic clk16,
   input  logic rst,
   input  logic serial_rx,
   output logic serial_tx
);

   localparam int              c_CNT_W    = $clog2(CLKS_PER_BIT);
   localparam logic [c_CNT_W-1:0] c_BIT_END  = c_CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [c_CNT_W-1:0] c_HALF_END = c_CNT_W'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } uart_st_t;

   logic               r_rx_meta, r_rx_sync;
   uart_st_t           r_rx_st, w_rx_nxt;
   logic [c_CNT_W-1:0] r_rx_cnt;
   logic [2:0]         r_rx_bit;
   logic [7:0]         r_rx_shift;
   logic               w_rx_tick, w_rx_done, w_rx_ferr;

   logic [7:0]         r_fifo [0:3];
   logic [1:0]         r_wr_ptr, r_rd_ptr;
   logic [2:0]         r_fifo_cnt;
   logic               w_fifo_full, w_fifo_empty, w_push, w_pop, w_ovf;

   logic [2:0]         r_ban_idx;
   logic               w_ban_done;
   logic [7:0]         w_ban_byte;

   uart_st_t           r_tx_st, w_tx_nxt;
   logic [c_CNT_W-1:0] r_tx_cnt;
   logic [2:0]         r_tx_bit;
   logic [7:0]         r_tx_shift;
   logic               r_txd, w_txd;
   logic               w_tx_tick, w_tx_load, w_tx_done, w_tx_avail;
   logic [7:0]         w_tx_byte;

   always_ff @(posedge clk16) begin
      if (!rst) begin
         r_rx_meta <= 1'b1;
         r_rx_sync <= 1'b1;
      end else begin
         r_rx_meta <= serial_rx;
         r_rx_sync <= r_rx_meta;
      end
   end

   always_comb begin
      w_rx_nxt  = r_rx_st;
      w_rx_tick = 1'b0;
      w_rx_done = 1'b0;
      w_rx_ferr = 1'b0;
      case (r_rx_st)
         S_IDLE: begin
            if (!r_rx_sync) w_rx_nxt = S_START;
         end
         S_START: begin
            w_rx_tick = (r_rx_cnt == c_HALF_END);
            if (w_rx_tick) w_rx_nxt = r_rx_sync ? S_IDLE : S_DATA;
         end
         S_DATA: begin
            w_rx_tick = (r_rx_cnt == c_BIT_END);
            if (w_rx_tick && (r_rx_bit == 3'd7)) w_rx_nxt = S_STOP;
         end
         S_STOP: begin
            w_rx_tick = (r_rx_cnt == c_BIT_END);
            if (w_rx_tick) begin
               w_rx_nxt  = S_IDLE;
               w_rx_done = r_rx_sync;
               w_rx_ferr = ~r_rx_sync;
            end
         end
         default: w_rx_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk16) begin
      if (!rst) begin
         r_rx_st    <= S_IDLE;
         r_rx_cnt   <= '0;
         r_rx_bit   <= 3'd0;
         r_rx_shift <= 8'd0;
      end else begin
         r_rx_st <= w_rx_nxt;
         if ((r_rx_st == S_IDLE) || w_rx_tick) r_rx_cnt <= '0;
         else                                  r_rx_cnt <= r_rx_cnt + 1'b1;
         if ((r_rx_st == S_DATA) && w_rx_tick) begin
            r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
            r_rx_bit   <= r_rx_bit + 3'd1;
         end
      end
   end

   assign w_fifo_full  = (r_fifo_cnt == 3'd4);
   assign w_fifo_empty = (r_fifo_cnt == 3'd0);
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
   assign w_push = w_rx_done & (~w_fifo_full | w_pop);
   assign w_ovf  = w_rx_done & w_fifo_full & ~w_pop;

   always_ff @(posedge clk16) begin
      if (w_push) r_fifo[r_wr_ptr] <= r_rx_shift;
   end

   always_ff @(posedge clk16) begin
      if (!rst) begin
         r_wr_ptr   <= 2'd0;
         r_rd_ptr   <= 2'd0;
         r_fifo_cnt <= 3'd0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
         case ({w_push, w_pop})
            2'b10:   r_fifo_cnt <= r_fifo_cnt + 3'd1;
            2'b01:   r_fifo_cnt <= r_fifo_cnt - 3'd1;
            default: r_fifo_cnt <= r_fifo_cnt;
         endcase
      end
   end

   assign w_ban_done = (r_ban_idx == 3'd6);

   always_comb begin
      case (r_ban_idx)
         3'd0:    w_ban_byte = 8'h42;
         3'd1:    w_ban_byte = 8'h4F;
         3'd2:    w_ban_byte = 8'h4F;
         3'd3:    w_ban_byte = 8'h54;
         3'd4:    w_ban_byte = 8'h0D;
         3'd5:    w_ban_byte = 8'h0A;
         default: w_ban_byte = 8'h00;
      endcase
   end

   assign w_tx_avail = ~w_ban_done | ~w_fifo_empty;
   assign w_tx_byte  = w_ban_done ? r_fifo[r_rd_ptr] : w_ban_byte;
   assign w_pop      = w_tx_load & w_ban_done;

   always_comb begin
      w_tx_nxt  = r_tx_st;
      w_tx_tick = 1'b0;
      w_tx_load = 1'b0;
      w_tx_done = 1'b0;
      w_txd     = 1'b1;
      case (r_tx_st)
         S_IDLE: begin
            if (w_tx_avail) begin
               w_tx_load = 1'b1;
               w_tx_nxt  = S_START;
            end
         end
         S_START: begin
            w_txd     = 1'b0;
            w_tx_tick = (r_tx_cnt == c_BIT_END);
            if (w_tx_tick) w_tx_nxt = S_DATA;
         end
         S_DATA: begin
            w_txd     = r_tx_shift[0];
            w_tx_tick = (r_tx_cnt == c_BIT_END);
            if (w_tx_tick && (r_tx_bit == 3'd7)) w_tx_nxt = S_STOP;
         end
         S_STOP: begin
            w_tx_tick = (r_tx_cnt == c_BIT_END);
            if (w_tx_tick) begin
               w_tx_done = 1'b1;
               if (w_tx_avail) begin
                  w_tx_load = 1'b1;
                  w_tx_nxt  = S_START;
               end else begin
                  w_tx_nxt  = S_IDLE;
               end
            end
         end
         default: w_tx_nxt = S_IDLE;
      endcase
   end

   // serial_tx is registered from the current state, giving a uniform one-cycle lag.
   always_ff @(posedge clk16) begin
      if (!rst) begin
         r_tx_st    <= S_IDLE;
         r_tx_cnt   <= '0;
         r_tx_bit   <= 3'd0;
         r_tx_shift <= 8'd0;
         r_ban_idx  <= 3'd0;
         r_txd      <= 1'b1;
      end else begin
         r_tx_st <= w_tx_nxt;
         r_txd   <= w_txd;
         if ((r_tx_st == S_IDLE) || w_tx_tick) r_tx_cnt <= '0;
         else                                  r_tx_cnt <= r_tx_cnt + 1'b1;
         if (w_tx_load) begin
            r_tx_shift <= w_tx_byte;
            r_tx_bit   <= 3'd0;
         end else if ((r_tx_st == S_DATA) && w_tx_tick) begin
            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
            r_tx_bit   <= r_tx_bit + 3'd1;
         end
         if (w_tx_load && !w_ban_done) r_ban_idx <= r_ban_idx + 3'd1;
      end
   end

   assign serial_tx = r_txd;

   soc_dbg_regs lm32_cpu (
      .clk         (clk16),
      .rst         (rst),
      .i_rx_valid  (w_rx_done),
      .i_rx_byte   (r_rx_shift),
      .i_tx_done   (w_tx_done),
      .i_frame_err (w_rx_ferr),
      .i_overflow  (w_ovf)
   );

endmodule
`default_nettype wire

// File: tb/tb_soc_top.sv
`default_nettype none
// ============================================================
// Module   : tb_soc_top
// Purpose  : self-checking bench for soc_top (banner, echo, errors, overflow)
// Revision : 1.0
// ============================================================
module tb_soc_top;

   localparam int CPB = 16;

   logic clk16 = 1'b0;
   logic rst;
   logic serial_rx;
   logic serial_tx;

   always #5 clk16 = ~clk16;

   soc_top #(.CLKS_PER_BIT(CPB)) dut (
      .clk16     (clk16),
      .rst       (rst),
      .serial_rx (serial_rx),
      .serial_tx (serial_tx)
   );

   typedef struct {
      logic [7:0] data;
      bit         b2b;
   } exp_t;

   typedef struct {
      bit          glitch;
      logic [7:0]  data;
      logic        stp;
      bit          echo;
      bit          lat;
      logic [31:0] r1;
      logic [31:0] r2;
      logic [31:0] r3;
      logic [31:0] r4;
   } vec_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   last_start = 0;
   bit   mon_busy = 1'b0;

   always @(posedge clk16) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic mwait(input int n, inout bit ab);
      repeat (n) begin
         @(negedge clk16);
         if (rst !== 1'b1) ab = 1'b1;
      end
   endtask

   // UART decoder on serial_tx; frames cut short by reset are discarded.
   initial begin : monitor
      bit         ab;
      logic [7:0] d;
      logic       s0, stp;
      int         st;
      exp_t       e;
      forever begin
         @(negedge clk16);
         if (rst === 1'b1 && serial_tx === 1'b0) begin
            mon_busy = 1'b1;
            ab = 1'b0;
            st = cyc;
            mwait(CPB / 2, ab);
            s0 = serial_tx;
            for (int i = 0; i < 8; i++) begin
               mwait(CPB, ab);
               d[i] = serial_tx;
            end
            mwait(CPB, ab);
            stp = serial_tx;
            if (!ab) begin
               if (sb.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL unexpected_frame: got 0x%0h, want no frame", d);
               end else begin
                  e = sb.pop_front();
                  check("tx_start_bit", {31'd0, s0}, 32'd0);
                  check("tx_byte", {24'd0, d}, {24'd0, e.data});
                  check("tx_stop_bit", {31'd0, stp}, 32'd1);
                  if (e.b2b) check("tx_gap", 32'(st - last_start), 32'(10 * CPB));
               end
               last_start = st;
            end
            mon_busy = 1'b0;
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input logic stp);
      serial_rx = 1'b0;
      repeat (CPB) @(negedge clk16);
      for (int i = 0; i < 8; i++) begin
         serial_rx = b[i];
         repeat (CPB) @(negedge clk16);
      end
      serial_rx = stp;
      repeat (CPB) @(negedge clk16);
      serial_rx = 1'b1;
   endtask

   task automatic drain(input string name);
      int t;
      t = 0;
      while ((sb.size() != 0 || mon_busy) && t < 4000) begin
         @(negedge clk16);
         t++;
      end
      check(name, 32'(sb.size()), 32'd0);
      repeat (40) @(negedge clk16);
   endtask

   task automatic push_banner();
      logic [7:0] ban [6];
      ban = '{8'h42, 8'h4F, 8'h4F, 8'h54, 8'h0D, 8'h0A};
      for (int i = 0; i < 6; i++) sb.push_back('{ban[i], (i != 0)});
   endtask

   task automatic enter_reset(input int n);
      rst = 1'b0;
      serial_rx = 1'b1;
      sb.delete();
      repeat (n) begin
         @(negedge clk16);
         check("tx_in_reset", {31'd0, serial_tx}, 32'd1);
      end
   endtask

   task automatic check_regs_zero(input string name);
      for (int i = 0; i < 32; i++) check(name, dut.lm32_cpu.registers[i], 32'd0);
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: got timeout, want $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      vec_t       tbl [6];
      int         dc;
      logic [7:0] ovf [6];

      tbl[0] = '{1'b0, 8'hA5, 1'b1, 1'b1, 1'b1, 32'd1, 32'd7,  32'hA5, 32'd0};
      tbl[1] = '{1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 32'd1, 32'd7,  32'hA5, 32'd1};
      tbl[2] = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 32'd1, 32'd7,  32'hA5, 32'd1};
      tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'd2, 32'd8,  32'h00, 32'd1};
      tbl[4] = '{1'b0, 8'hFF, 1'b1, 1'b1, 1'b0, 32'd3, 32'd9,  32'hFF, 32'd1};
      tbl[5] = '{1'b0, 8'h80, 1'b1, 1'b1, 1'b0, 32'd4, 32'd10, 32'h80, 32'd1};
      ovf    = '{8'hC1, 8'h22, 8'h93, 8'h44, 8'h5E, 8'h6F};

      // Reset and banner
      enter_reset(3);
      check_regs_zero("reg_after_reset");
      push_banner();
      dc = cyc;
      rst = 1'b1;
      drain("banner_drained");
      check("banner_first_start", 32'(last_start - 50 * CPB), 32'(dc + 2));
      check("banner_r2", dut.lm32_cpu.registers[2], 32'd6);
      check("banner_r1", dut.lm32_cpu.registers[1], 32'd0);

      // Echo, framing error, glitch and further echoes
      for (int i = 0; i < 6; i++) begin
         if (tbl[i].echo) sb.push_back('{tbl[i].data, 1'b0});
         dc = cyc;
         if (tbl[i].glitch) begin
            serial_rx = 1'b0;
            repeat (4) @(negedge clk16);
            serial_rx = 1'b1;
            repeat (200) @(negedge clk16);
         end else begin
            send_byte(tbl[i].data, tbl[i].stp);
         end
         drain("vec_drained");
         if (tbl[i].lat) check("echo_latency", 32'(last_start - dc), 32'd157);
         check("vec_r1", dut.lm32_cpu.registers[1], tbl[i].r1);
         check("vec_r2", dut.lm32_cpu.registers[2], tbl[i].r2);
         check("vec_r3", dut.lm32_cpu.registers[3], tbl[i].r3);
         check("vec_r4", dut.lm32_cpu.registers[4], tbl[i].r4);
      end

      // Bytes received during the banner follow it with no gap
      enter_reset(2);
      push_banner();
      sb.push_back('{8'h31, 1'b1});
      sb.push_back('{8'h32, 1'b1});
      sb.push_back('{8'h33, 1'b1});
      rst = 1'b1;
      send_byte(8'h31, 1'b1);
      send_byte(8'h32, 1'b1);
      send_byte(8'h33, 1'b1);
      drain("queued_drained");
      check("queued_r2", dut.lm32_cpu.registers[2], 32'd9);
      check("queued_r1", dut.lm32_cpu.registers[1], 32'd3);
      check("queued_r3", dut.lm32_cpu.registers[3], 32'h33);

      // Overflow: six bytes arrive while the banner holds the FIFO
      enter_reset(2);
      push_banner();
      for (int i = 0; i < 4; i++) sb.push_back('{ovf[i], 1'b1});
      rst = 1'b1;
      for (int i = 0; i < 6; i++) send_byte(ovf[i], 1'b1);
      drain("ovf_drained");
      check("ovf_r5", dut.lm32_cpu.registers[5], 32'd2);
      check("ovf_r1", dut.lm32_cpu.registers[1], 32'd6);
      check("ovf_r3", dut.lm32_cpu.registers[3], 32'h6F);
      check("ovf_r2", dut.lm32_cpu.registers[2], 32'd10);
      check("ovf_r4", dut.lm32_cpu.registers[4], 32'd0);

      // Reset with both RX and TX mid-frame
      send_byte(8'h77, 1'b1);
      serial_rx = 1'b0;
      repeat (30) @(negedge clk16);
      check("pre_reset_r1", dut.lm32_cpu.registers[1], 32'd7);
      check("pre_reset_tx_busy", {31'd0, mon_busy}, 32'd1);
      rst = 1'b0;
      serial_rx = 1'b1;
      @(negedge clk16);
      check("tx_after_midreset", {31'd0, serial_tx}, 32'd1);
      check_regs_zero("reg_after_midreset");
      repeat (3) @(negedge clk16);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/soc_top.md
# soc_top

Minimal serial SoC top for the TinyFPGA target: one 8N1 UART receiver, one 8N1 UART transmitter, a 4-entry echo FIFO, a fixed boot-banner sequencer and a 32×32 debug register file. After reset it transmits a banner, then echoes every correctly framed received byte. It is the top-level wrapper instantiated by the board and by the system simulation bench.

## Interface
- `CLKS_PER_BIT`, default 278: clock cycles per UART bit (32 MHz / 115200). Must be ≥ 4.
- `clk16` input, 1 bit: system clock. The name is historical; the nominal frequency is 32 MHz (31.25 ns period).
- `rst` input, 1 bit: reset, synchronous and active-low. Sampled on the `clk16` rising edge.
- `serial_rx` input, 1 bit: UART receive line. Asynchronous, idle high.
- `serial_tx` output, 1 bit: UART transmit line. Idle high.

## Operation
- **Reset (`rst`=0 at a clock edge):**
  - `serial_tx`=1; TX idle; RX idle.
  - FIFO empty.
  - Banner index = 0.
  - All debug registers cleared to 0.
  - Reset mid-frame aborts both RX and TX immediately.
- **RX synchroniser:** `serial_rx` passes through a 2-flop synchroniser. All RX logic uses the synchronised value.
- **RX state machine (IDLE → START → DATA → STOP → IDLE):**
  - IDLE: a synchronised low level starts a frame.
  - START: waits CLKS_PER_BIT/2 cycles (integer division). If the line is high at that point, the frame is a false start and RX returns to IDLE.
  - DATA: samples 8 bits, LSB first, every CLKS_PER_BIT cycles.
  - STOP: samples the stop bit CLKS_PER_BIT cycles after the last data bit.
    - Stop = 1: byte is valid.
    - Stop = 0: framing error. The byte is discarded and `registers[4]` increments.
    - RX returns to IDLE in the same cycle the stop bit is sampled.
- **Valid received byte:**
  - `registers[1]` increments.
  - `registers[3]` = byte (zero-extended).
  - Byte is pushed into the FIFO. If the FIFO is full, the byte is dropped and `registers[5]` increments.
- **Banner:** the 6 bytes 0x42 0x4F 0x4F 0x54 0x0D 0x0A ("BOOT\r\n") are sent once after reset, in that order. The banner has priority over the FIFO until all 6 bytes are sent.
- **TX state machine (IDLE → START → DATA → STOP → IDLE):**
  - Each frame: start bit 0, 8 data bits LSB first, stop bit 1. Every bit lasts exactly CLKS_PER_BIT cycles.
  - On leaving STOP, TX loads the next byte if one is available, so there is no idle gap between frames.
  - Byte source: banner byte while the banner is incomplete; otherwise the FIFO head (popped on load).
  - Each completed frame increments `registers[2]`.
- **FIFO:** 4 entries × 8 bits.
  - A simultaneous push and pop when full is allowed and the pushed byte is not dropped.
  - Pop when empty is not possible.
- **Debug register file:**
  - 32 × 32-bit array named `registers`, inside an instance named `lm32_cpu`. Hierarchical path: `<top>.lm32_cpu.registers[0..31]`.
  - `registers[0]` is always 0.
  - Entries 6–31 remain 0.
  - All counters wrap modulo 2^32.

## Timing
- First start bit (`serial_tx`=0) appears on the second rising edge after `rst` is first sampled high.
- Banner duration: 60·CLKS_PER_BIT cycles, back-to-back.
- RX sample points, measured from the first synchronised low:
  - start: CLKS_PER_BIT/2
  - data bit k: CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT
  - stop: CLKS_PER_BIT/2 + 9·CLKS_PER_BIT
- Push and counter updates are visible one cycle after the stop sample.
- Echo latency: when TX is idle and the banner is done, the echo start bit begins 2 cycles after the stop-bit sample.
- Synchroniser adds 2 cycles from a `serial_rx` edge to the RX state machine.

## Test plan
- **Reset and banner:** hold `rst`=0 for 3 cycles, then release with `serial_rx`=1 and CLKS_PER_BIT=16. Required:
  - `serial_tx`=1 during reset.
  - "BOOT\r\n" decoded back-to-back, 960 cycles total.
  - `registers[2]`=6.
- **Echo:** after the banner, send 0xA5 at 16 cycles/bit. Required:
  - 0xA5 echoed on `serial_tx`.
  - `registers[1]`=1, `registers[3]`=0xA5, `registers[2]`=7.
- **Queued during banner:** send 0x31, 0x32, 0x33 while the banner is in progress. Required: output is the banner, then 0x31 0x32 0x33 with no gaps.
- **Framing error:** send 0x55 with stop bit 0. Required:
  - No echo.
  - `registers[4]`=1, `registers[1]` unchanged.
- **Glitch:** pull `serial_rx` low for 4 cycles (less than half a bit). Required: no byte, no counter change.
- **Overflow and reset:**
  - Send 6 bytes back-to-back during the banner. Required: 4 bytes echoed after the banner, `registers[5]`=2.
  - Then assert `rst` mid-frame. Required: `serial_tx`=1 next cycle and all registers read 0.
